// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, direction codes and FSM state types
// used by the keyboard front end and the digger/bullet blocks.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RIGHT = 2'b11;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {SC_IDLE, SC_E0, SC_F0, SC_E0F0} sc_state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HIGH, ST_GAP} st_state_t;

  typedef struct packed {
    rx_state_t rx;
    sc_state_t sc;
    st_state_t st;
  } dbg_t;

  function automatic logic is_dir(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_DOWN) ||
           (code == SC_LEFT) || (code == SC_RIGHT);
  endfunction

  function automatic logic [1:0] dir_of(input logic [7:0] code);
    case (code)
      SC_UP:   dir_of = UP;
      SC_DOWN: dir_of = DOWN;
      SC_LEFT: dir_of = LEFT;
      default: dir_of = RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Player-input output bundle: direction bus with sample strobe, fire and
// frame error pulses, plus FSM state for observation.
interface ps2_dir_decoder_if;
  import ps2_pkg::*;

  // Not a valid/ready channel: sample qualifies keyboard, fire and
  // frame_err are single-cycle pulses; the consumer cannot stall.
  logic [1:0] keyboard;
  logic       sample;
  logic       fire;
  logic       frame_err;
  dbg_t       dbg;

  modport master (output keyboard, sample, fire, frame_err, dbg);
  modport slave  (input  keyboard, sample, fire, frame_err, dbg);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 receiver: line synchronizers, clock glitch filter, 11-bit frame
// deframer with odd-parity check and mid-frame watchdog.
module ps2_rx
  import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output rx_state_t  state_dbg
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

  logic clk_s1, clk_s2, data_s1, data_s2;
  logic filt_clk;
  logic [FW-1:0] filt_cnt;
  logic bit_event;

  rx_state_t state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic par, par_n;
  logic [WW-1:0] wd, wd_n;
  logic valid_n, err_n;

  // Lines idle high, so synchronizers reset to 1 to avoid a fake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FILT_LAST) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign bit_event = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    wd_n      = wd;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (state != RX_IDLE) wd_n = wd + 1'b1;
    if (bit_event) begin
      wd_n = '0;
      case (state)
        RX_IDLE: begin
          if (!data_s2) begin
            state_n   = RX_DATA;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        RX_DATA: begin
          shift_n   = {data_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
        RX_PARITY: begin
          par_n   = data_s2;
          state_n = RX_STOP;
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          if (data_s2 && (^{shift, par})) valid_n = 1'b1;
          else                            err_n   = 1'b1;
        end
      endcase
    end else if ((state != RX_IDLE) && (wd == WD_LAST)) begin
      state_n = RX_IDLE;
      wd_n    = '0;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      wd         <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bit_cnt    <= bit_cnt_n;
      par        <= par_n;
      wd         <= wd_n;
      byte_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  assign rx_byte   = shift;
  assign state_dbg = state;

endmodule

// File: rtl/ps2_dir_decoder.sv
// Keyboard front end: decodes arrow/space make codes into the digger's
// direction bus with a sample strobe and a fire pulse.
module ps2_dir_decoder
  import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT     = 50000,
    parameter int SAMPLE_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_dir_decoder_if.master dir_bus
);

  localparam int HW = (SAMPLE_HOLD > 1) ? $clog2(SAMPLE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(SAMPLE_HOLD - 1);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rx_err;
  rx_state_t  rx_state;

  ps2_rx #(
      .FILTER_LEN(FILTER_LEN),
      .TIMEOUT   (TIMEOUT)
  ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .frame_err (rx_err),
      .state_dbg (rx_state)
  );

  sc_state_t sc, sc_n;
  logic fire_n, fire_q;
  logic dir_evt;
  logic [1:0] dir_code;

  always_comb begin
    sc_n     = sc;
    fire_n   = 1'b0;
    dir_evt  = 1'b0;
    dir_code = dir_of(rx_byte);
    if (byte_valid) begin
      case (sc)
        SC_IDLE: begin
          if (rx_byte == SC_EXT)        sc_n   = SC_E0;
          else if (rx_byte == SC_BREAK) sc_n   = SC_F0;
          else if (rx_byte == SC_SPACE) fire_n = 1'b1;
        end
        SC_E0: begin
          if (rx_byte == SC_EXT) begin
            sc_n = SC_E0;
          end else if (rx_byte == SC_BREAK) begin
            sc_n = SC_E0F0;
          end else begin
            sc_n    = SC_IDLE;
            dir_evt = is_dir(rx_byte);
          end
        end
        SC_F0, SC_E0F0: sc_n = SC_IDLE;
      endcase
    end
  end

  st_state_t st, st_n;
  logic [1:0] kb_q, kb_n;
  logic smp_q, smp_n;
  logic [HW-1:0] hold, hold_n;
  logic pend, pend_n;
  logic [1:0] pcode, pcode_n;

  // keyboard may only change while sample is low; events that arrive
  // once a strobe is committed wait in a one-deep, newest-wins slot.
  always_comb begin
    st_n    = st;
    kb_n    = kb_q;
    smp_n   = smp_q;
    hold_n  = hold;
    pend_n  = pend;
    pcode_n = pcode;
    case (st)
      ST_IDLE, ST_GAP: begin
        smp_n = 1'b0;
        st_n  = ST_IDLE;
        if (dir_evt) begin
          kb_n   = dir_code;
          pend_n = 1'b0;
          st_n   = ST_LOAD;
        end else if (pend) begin
          kb_n   = pcode;
          pend_n = 1'b0;
          st_n   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        smp_n  = 1'b1;
        hold_n = '0;
        st_n   = ST_HIGH;
        if (dir_evt) begin
          pend_n  = 1'b1;
          pcode_n = dir_code;
        end
      end
      ST_HIGH: begin
        if (dir_evt) begin
          pend_n  = 1'b1;
          pcode_n = dir_code;
        end
        if (hold == HOLD_LAST) begin
          smp_n = 1'b0;
          st_n  = ST_GAP;
        end else begin
          hold_n = hold + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc     <= SC_IDLE;
      fire_q <= 1'b0;
      st     <= ST_IDLE;
      kb_q   <= LEFT;
      smp_q  <= 1'b0;
      hold   <= '0;
      pend   <= 1'b0;
      pcode  <= LEFT;
    end else begin
      sc     <= sc_n;
      fire_q <= fire_n;
      st     <= st_n;
      kb_q   <= kb_n;
      smp_q  <= smp_n;
      hold   <= hold_n;
      pend   <= pend_n;
      pcode  <= pcode_n;
    end
  end

  assign dir_bus.keyboard  = kb_q;
  assign dir_bus.sample    = smp_q;
  assign dir_bus.fire      = fire_q;
  assign dir_bus.frame_err = rx_err;
  assign dir_bus.dbg       = '{rx: rx_state, sc: sc, st: st};

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Bench for ps2_dir_decoder: two instances (short and long sample hold)
// share the PS/2 lines; a scan-level model predicts strobes, fire and errors.
module tb_ps2_dir_decoder;
  import ps2_pkg::*;

  localparam int FILT   = 4;
  localparam int TMO    = 300;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 450;
  localparam int HALF   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clk = ~clk;

  ps2_dir_decoder_if bus_a ();
  ps2_dir_decoder_if bus_b ();

  ps2_dir_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TMO), .SAMPLE_HOLD(HOLD_A)) dut_a (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .dir_bus(bus_a));
  ps2_dir_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TMO), .SAMPLE_HOLD(HOLD_B)) dut_b (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .dir_bus(bus_b));

  logic [1:0] kb_w[2];
  logic smp_w[2], fire_w[2], err_w[2];
  always_comb begin
    kb_w[0] = bus_a.keyboard;  kb_w[1] = bus_b.keyboard;
    smp_w[0] = bus_a.sample;   smp_w[1] = bus_b.sample;
    fire_w[0] = bus_a.fire;    fire_w[1] = bus_b.fire;
    err_w[0] = bus_a.frame_err; err_w[1] = bus_b.frame_err;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scan-level model ----------------
  logic [1:0] exp_q[$];
  bit pre_ext = 0;
  bit pre_brk = 0;

  task automatic model_byte(input logic [7:0] b);
    if (pre_brk) begin
      pre_brk = 0;
      pre_ext = 0;
    end else if (b == 8'hF0) begin
      pre_brk = 1;
    end else if (b == 8'hE0) begin
      pre_ext = 1;
    end else begin
      if (pre_ext) begin
        case (b)
          8'h75: exp_q.push_back(2'b00);
          8'h72: exp_q.push_back(2'b01);
          8'h6B: exp_q.push_back(2'b10);
          8'h74: exp_q.push_back(2'b11);
          default: ;
        endcase
      end
      pre_ext = 0;
    end
  endtask

  // ---------------- compare process ----------------
  logic prev_smp[2], prev_fire[2];
  logic [1:0] prev_kb[2];
  int high_len[2] = '{0, 0};
  int fire_len[2] = '{0, 0};
  int pos[2] = '{0, 0};
  int fire_cnt[2] = '{0, 0};
  int err_cnt[2] = '{0, 0};
  int hold_len[2] = '{HOLD_A, HOLD_B};

  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (smp_w[i] && !prev_smp[i]) begin
          chk($sformatf("kb_before_rise%0d", i), kb_w[i], prev_kb[i]);
          chk($sformatf("strobe_count%0d", i), pos[i] + 1 <= exp_q.size(), 1);
          if (pos[i] < exp_q.size())
            chk($sformatf("strobe_kb%0d", i), kb_w[i], exp_q[pos[i]]);
          pos[i]++;
          high_len[i] = 1;
        end else if (smp_w[i]) begin
          chk($sformatf("kb_stable_high%0d", i), kb_w[i], prev_kb[i]);
          high_len[i]++;
        end else if (prev_smp[i]) begin
          chk($sformatf("high_len%0d", i), high_len[i], hold_len[i]);
        end
        if (fire_w[i]) begin
          if (!prev_fire[i]) fire_cnt[i]++;
          fire_len[i]++;
        end else if (prev_fire[i]) begin
          chk($sformatf("fire_width%0d", i), fire_len[i], 1);
        end
        if (err_w[i]) err_cnt[i]++;
      end
      if (!fire_w[i]) fire_len[i] = 0;
      if (!smp_w[i]) high_len[i] = 0;
      prev_smp[i]  = smp_w[i];
      prev_fire[i] = fire_w[i];
      prev_kb[i]   = kb_w[i];
    end
  end

  // ---------------- drivers ----------------
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ps2_data = bits[k];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    if (!bad_par) model_byte(b);
    send_bits({1'b1, p, b, 1'b0}, 11);
  endtask

  task automatic end_test(input string name, input logic [1:0] kb_e, input int strobes_e,
                          input int fire_e, input int err_e);
    repeat (2 * HOLD_B + 40) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_kb%0d", name, i), kb_w[i], kb_e);
      chk($sformatf("%s_strobes%0d", name, i), pos[i], strobes_e);
      chk($sformatf("%s_model_strobes%0d", name, i), pos[i], exp_q.size());
      chk($sformatf("%s_fires%0d", name, i), fire_cnt[i], fire_e);
      chk($sformatf("%s_errs%0d", name, i), err_cnt[i], err_e);
    end
  endtask

  bit drv_done;
  bit seen;

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_kb%0d", i), kb_w[i], 2'b10);
      chk($sformatf("rst_sample%0d", i), smp_w[i], 0);
      chk($sformatf("rst_fire%0d", i), fire_w[i], 0);
      chk($sformatf("rst_err%0d", i), err_w[i], 0);
    end
    chk("rst_rx_state", bus_a.dbg.rx, RX_IDLE);
    chk("rst_sc_state", bus_a.dbg.sc, SC_IDLE);
    chk("rst_st_state", bus_b.dbg.st, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // UP make
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    end_test("up", 2'b00, 1, 0, 0);

    // E0 then 74 with bad parity, then a clean RIGHT make
    send_frame(8'hE0, 0);
    send_frame(8'h74, 1);
    send_frame(8'hE0, 0);
    send_frame(8'h74, 0);
    end_test("parity", 2'b11, 2, 0, 1);

    // LEFT break after RIGHT make
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h6B, 0);
    end_test("break", 2'b11, 2, 0, 1);

    // DOWN then LEFT back to back (pending path on the long-hold instance)
    send_frame(8'hE0, 0);
    send_frame(8'h72, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h6B, 0);
    end_test("pending", 2'b10, 4, 0, 1);

    // truncated frame then watchdog, then UP
    send_bits({6'b000000, 4'b1010, 1'b0}, 5);
    repeat (TMO + 50) @(negedge clk);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    end_test("timeout", 2'b00, 5, 0, 2);

    // space make
    send_frame(8'h29, 0);
    end_test("fire", 2'b00, 5, 1, 2);

    // reset in the middle of a strobe
    drv_done = 0;
    fork
      begin
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        drv_done = 1;
      end
    join_none
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = bus_a.sample;
    end
    chk("rst_test_rise_seen", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_sample%0d", i), smp_w[i], 0);
      chk($sformatf("midrst_kb%0d", i), kb_w[i], 2'b10);
    end
    @(negedge clk);
    rst = 1'b0;
    pre_ext = 0;
    pre_brk = 0;
    for (int c = 0; c < 3000 && !drv_done; c++) @(posedge clk);
    chk("driver_done", drv_done, 1);
    end_test("after_rst", 2'b10, 6, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
